// File: rtl/event_responder.sv
// Event counter with a one-at-a-time service handshake: trig queues events, svc_req/svc_ack retires them.
// From idle, a trig raises svc_req two cycles later; with no svc_ack for TIMEOUT cycles, the event is dropped.
module event_responder #(
  parameter int MAX_PEND = 15,
  parameter int TIMEOUT  = 16,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             trig,
  input  logic             svc_ack,
  input  logic             clr_flags,
  output logic             svc_req,
  output logic [3:0]       pend_cnt,
  output logic [CNT_W-1:0] done_cnt,
  output logic             overflow,
  output logic             timeout
);

  typedef enum logic [1:0] {IDLE, REQ, GAP} state_t;

  state_t           state_q;
  logic             svc_req_q;
  logic [7:0]       tcnt_q;
  logic [3:0]       pend_q, pend_d;
  logic [CNT_W-1:0] done_q, done_d;
  logic             ovf_q, ovf_d;
  logic             to_q, to_d;
  logic             acked, expired, retire;

  // An ack on the final allowed cycle still counts as an ack.
  assign acked   = (state_q == REQ) && svc_ack;
  assign expired = (state_q == REQ) && !svc_ack && (tcnt_q == 8'(TIMEOUT - 1));
  assign retire  = acked || expired;

  always_comb begin
    pend_d = pend_q;
    done_d = done_q;
    ovf_d  = ovf_q;
    to_d   = to_q;
    if (clr_flags) begin
      ovf_d = 1'b0;
      to_d  = 1'b0;
    end
    // A trig alongside a retire cancels out, so saturation cannot lose it.
    if (trig && !retire) begin
      if (pend_q == 4'(MAX_PEND)) begin
        ovf_d = 1'b1;
      end else begin
        pend_d = pend_q + 4'd1;
      end
    end else if (!trig && retire) begin
      pend_d = pend_q - 4'd1;
    end
    if (acked) begin
      done_d = done_q + CNT_W'(1);
    end
    if (expired) begin
      to_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q <= 4'd0;
      done_q <= '0;
      ovf_q  <= 1'b0;
      to_q   <= 1'b0;
    end else begin
      pend_q <= pend_d;
      done_q <= done_d;
      ovf_q  <= ovf_d;
      to_q   <= to_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      svc_req_q <= 1'b0;
      tcnt_q    <= 8'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pend_q != 4'd0) begin
            state_q   <= REQ;
            svc_req_q <= 1'b1;
            tcnt_q    <= 8'd0;
          end
        end
        REQ: begin
          if (retire) begin
            state_q   <= GAP;
            svc_req_q <= 1'b0;
            tcnt_q    <= 8'd0;
          end else begin
            tcnt_q <= tcnt_q + 8'd1;
          end
        end
        GAP: begin
          if (pend_q != 4'd0) begin
            state_q   <= REQ;
            svc_req_q <= 1'b1;
            tcnt_q    <= 8'd0;
          end else begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q   <= IDLE;
          svc_req_q <= 1'b0;
          tcnt_q    <= 8'd0;
        end
      endcase
    end
  end

  assign svc_req  = svc_req_q;
  assign pend_cnt = pend_q;
  assign done_cnt = done_q;
  assign overflow = ovf_q;
  assign timeout  = to_q;

endmodule

// File: doc/event_responder.md
EVENT_RESPONDER -- requirements
Module: event_responder

Interface
REQ-001 Parameter MAX_PEND, default 15, SHALL set the saturation value of the pending-event counter (1..15).
REQ-002 Parameter TIMEOUT, default 16, SHALL set the number of svc_req-high cycles allowed without svc_ack before the event is dropped (2..255).
REQ-003 Parameter CNT_W, default 8, SHALL set the width of done_cnt.
REQ-004 The block SHALL use one clock and a synchronous, active-high reset.
REQ-005 Port clk, input, 1 bit, SHALL be the sole clock; all state updates on its rising edge.
REQ-006 Port rst, input, 1 bit, SHALL be the synchronous active-high reset.
REQ-007 Port trig, input, 1 bit, SHALL carry one event trigger per cycle sampled high.
REQ-008 Port svc_ack, input, 1 bit, SHALL be the handler acknowledge for the current svc_req.
REQ-009 Port clr_flags, input, 1 bit, SHALL clear the sticky overflow and timeout flags when high.
REQ-010 Port svc_req, output, 1 bit, SHALL request service of one pending event.
REQ-011 Port pend_cnt, output, 4 bits, SHALL show the number of pending (unserviced) events.
REQ-012 Port done_cnt, output, CNT_W bits, SHALL count events successfully acknowledged.
REQ-013 Port overflow, output, 1 bit, SHALL be a sticky flag for triggers lost at saturation.
REQ-014 Port timeout, output, 1 bit, SHALL be a sticky flag for events dropped by timeout.

Function
REQ-015 The FSM SHALL have states IDLE, REQ and GAP; svc_req SHALL be high only in REQ (registered output).
REQ-016 IDLE SHALL go to REQ on the next edge when registered pend_cnt != 0, else stay IDLE.
REQ-017 REQ with svc_ack high SHALL decrement pend_cnt, increment done_cnt (wrap modulo 2^CNT_W), and go to GAP.
REQ-018 REQ SHALL count cycles from entry; when svc_req has been high TIMEOUT cycles without svc_ack, the block SHALL decrement pend_cnt, set timeout, leave done_cnt unchanged, and go to GAP.
REQ-019 svc_ack in the same cycle as the timeout limit SHALL count as acknowledged (REQ-017 wins).
REQ-020 GAP SHALL last exactly one cycle with svc_req low, then go to REQ if pend_cnt != 0 else IDLE.
REQ-021 svc_ack outside REQ SHALL be ignored.
REQ-022 trig high SHALL increment pend_cnt by one unless pend_cnt == MAX_PEND.
REQ-023 trig and a decrement (REQ-017/018) in the same cycle SHALL leave pend_cnt unchanged, including at MAX_PEND (no overflow).
REQ-024 trig at MAX_PEND without a same-cycle decrement SHALL drop the trigger and set overflow.
REQ-025 Latency: trig in cycle N with pend_cnt == 0 in IDLE SHALL yield pend_cnt == 1 at N+1 and svc_req high at N+2.
REQ-026 clr_flags SHALL clear overflow/timeout next edge; a same-cycle set condition SHALL take priority (flag stays 1).

Reset
REQ-027 rst high SHALL force, next edge: state IDLE, svc_req 0, pend_cnt 0, done_cnt 0, overflow 0, timeout 0, timeout counter 0.
REQ-028 rst mid-handshake (REQ) SHALL discard all pending events; svc_req SHALL be low the cycle after the reset edge.
REQ-029 rst SHALL take priority over trig, svc_ack and clr_flags.

Verification
REQ-030 Single trig at cycle 10, svc_ack at first svc_req -> svc_req high at cycle 12, pend_cnt 1→0, done_cnt = 1, svc_req low in GAP.
REQ-031 Five back-to-back trigs, svc_ack held high -> five REQ/GAP pairs, done_cnt = 5, pend_cnt ends 0, no flags.
REQ-032 16 trigs with svc_ack low (MAX_PEND 15) -> pend_cnt saturates at 15, overflow = 1; trig coincident with timeout at 15 -> pend_cnt stays 15.
REQ-033 One trig, svc_ack never high (TIMEOUT 16) -> svc_req high exactly 16 cycles, timeout = 1, done_cnt = 0, pend_cnt = 0; svc_ack on cycle 16 instead -> done_cnt = 1, timeout = 0.
REQ-034 rst asserted while in REQ with pend_cnt = 3 -> all outputs 0 next cycle; clr_flags with coincident overflow -> overflow stays 1.
REQ-035 done_cnt at 255 (CNT_W 8) plus one ack -> done_cnt = 0.
